tlb_lru_tracker: RTL and testbench

//  Sequential, parametrised successor to the combinational tlb_lru victim picker.

---
 rtl/tlb_lru_tracker_pkg.sv | 17 +
 rtl/tlb_lru_tracker_select.sv | 54 +++++
 rtl/tlb_lru_tracker.sv | 128 ++++++++++++
 tb/tb_tlb_lru_tracker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_lru_tracker_pkg.sv
// Shared defaults, FSM encoding and width helper for the TLB LRU tracker.
package tlb_lru_tracker_pkg;

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_NUM_SETS = 16;
    localparam int DEF_LRU_BITS = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RENORM = 1'b1
    } lru_state_e;

    function automatic int set_bits(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

endpackage

// File: rtl/tlb_lru_tracker_select.sv
// Combinational per-set view: victim way, max stamp, any-invalid flag and
// the stable rank of every stamp within the set.
module tlb_lru_tracker_select
    import tlb_lru_tracker_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int LRU_BITS = DEF_LRU_BITS,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][LRU_BITS-1:0] stamps,
    input  logic [NUM_WAYS-1:0]               valid,
    output logic [WAY_BITS-1:0]               victim,
    output logic [LRU_BITS-1:0]               max_stamp,
    output logic                              any_inv,
    output logic [NUM_WAYS-1:0][WAY_BITS-1:0] rank
);

    logic [LRU_BITS-1:0] min_stamp;
    logic [WAY_BITS-1:0] min_way;

    // Downward scan leaves the lowest invalid index; strict < keeps ties on the lowest index.
    always_comb begin
        any_inv   = 1'b0;
        victim    = '0;
        max_stamp = '0;
        min_stamp = stamps[0];
        min_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_inv = 1'b1;
                victim  = WAY_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (stamps[i] > max_stamp) max_stamp = stamps[i];
            if (stamps[i] < min_stamp) begin
                min_stamp = stamps[i];
                min_way   = WAY_BITS'(i);
            end
        end
        if (!any_inv) victim = min_way;
    end

    always_comb begin
        rank = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            for (int j = 0; j < NUM_WAYS; j++) begin
                if ((stamps[j] < stamps[i]) || ((stamps[j] == stamps[i]) && (j < i)))
                    rank[i] = rank[i] + WAY_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/tlb_lru_tracker.sv
// Per-set recency tracker beside the TLB tag array: stamps, valid bits,
// registered victim responses and a one-cycle renormalise on stamp saturation.
module tlb_lru_tracker
    import tlb_lru_tracker_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int LRU_BITS = DEF_LRU_BITS,
    localparam int WAY_BITS = $clog2(NUM_WAYS),
    localparam int SET_BITS = set_bits(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inv_valid,
    input  logic [SET_BITS-1:0] inv_set,
    input  logic [WAY_BITS-1:0] inv_way,
    input  logic                touch_valid,
    output logic                touch_ready,
    input  logic [SET_BITS-1:0] touch_set,
    input  logic [WAY_BITS-1:0] touch_way,
    input  logic                query_valid,
    input  logic [SET_BITS-1:0] query_set,
    output logic                resp_valid,
    output logic [WAY_BITS-1:0] resp_way,
    output logic [LRU_BITS-1:0] resp_max,
    output logic                resp_inv,
    output logic                busy
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][LRU_BITS-1:0] stamp_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]               valid_q;
    lru_state_e                                      state_q;
    logic [SET_BITS-1:0]                             lat_set_q;
    logic [WAY_BITS-1:0]                             lat_way_q;

    logic [WAY_BITS-1:0]               q_victim, u_victim;
    logic [LRU_BITS-1:0]               q_max, u_max;
    logic                              q_any_inv, u_any_inv;
    logic [NUM_WAYS-1:0][WAY_BITS-1:0] q_rank, u_rank;
    logic [SET_BITS-1:0]               upd_set;
    logic [NUM_WAYS-1:0][LRU_BITS-1:0] renorm_stamps;
    logic                              sel_unused;

    assign upd_set     = (state_q == ST_RENORM) ? lat_set_q : touch_set;
    assign touch_ready = !flush && !inv_valid && (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RENORM);
    assign sel_unused  = ^{q_rank, u_victim, u_any_inv};

    tlb_lru_tracker_select #(.NUM_WAYS(NUM_WAYS), .LRU_BITS(LRU_BITS)) u_query_sel (
        .stamps    (stamp_q[query_set]),
        .valid     (valid_q[query_set]),
        .victim    (q_victim),
        .max_stamp (q_max),
        .any_inv   (q_any_inv),
        .rank      (q_rank)
    );

    tlb_lru_tracker_select #(.NUM_WAYS(NUM_WAYS), .LRU_BITS(LRU_BITS)) u_update_sel (
        .stamps    (stamp_q[upd_set]),
        .valid     (valid_q[upd_set]),
        .victim    (u_victim),
        .max_stamp (u_max),
        .any_inv   (u_any_inv),
        .rank      (u_rank)
    );

    // The latched way is pulled out of the ranking, so the others pack into
    // 0..NUM_WAYS-2 in their old order and the latched way lands on NUM_WAYS.
    always_comb begin
        renorm_stamps = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_BITS'(w) == lat_way_q)
                renorm_stamps[w] = LRU_BITS'(NUM_WAYS);
            else if (u_rank[w] > u_rank[lat_way_q])
                renorm_stamps[w] = LRU_BITS'(u_rank[w]) - LRU_BITS'(1);
            else
                renorm_stamps[w] = LRU_BITS'(u_rank[w]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_q    <= '0;
            valid_q    <= '0;
            state_q    <= ST_IDLE;
            lat_set_q  <= '0;
            lat_way_q  <= '0;
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_max   <= '0;
            resp_inv   <= 1'b0;
        end else begin
            resp_valid <= query_valid;
            if (query_valid) begin
                resp_way <= q_victim;
                resp_max <= q_max;
                resp_inv <= q_any_inv;
            end
            if (flush) begin
                stamp_q <= '0;
                valid_q <= '0;
                state_q <= ST_IDLE;
            end else begin
                if (state_q == ST_RENORM) begin
                    stamp_q[lat_set_q]            <= renorm_stamps;
                    valid_q[lat_set_q][lat_way_q] <= 1'b1;
                    state_q                       <= ST_IDLE;
                end else if (touch_valid && touch_ready) begin
                    if (u_max == '1) begin
                        lat_set_q <= touch_set;
                        lat_way_q <= touch_way;
                        state_q   <= ST_RENORM;
                    end else begin
                        stamp_q[touch_set][touch_way] <= u_max + LRU_BITS'(1);
                        valid_q[touch_set][touch_way] <= 1'b1;
                    end
                end
                // Issued last so an invalidate overrides a same-cycle renormalise.
                if (inv_valid) begin
                    stamp_q[inv_set][inv_way] <= '0;
                    valid_q[inv_set][inv_way] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_lru_tracker.sv
// Directed plus random stimulus for tlb_lru_tracker, checked against an
// array-based recency model.
module tb_tlb_lru_tracker;

    localparam int NW = 4;
    localparam int NS = 16;
    localparam int LB = 4;
    localparam int SAT = (1 << LB) - 1;

    logic       clk = 1'b0;
    logic       rst, flush, inv_valid, touch_valid, touch_ready, query_valid;
    logic [3:0] inv_set, touch_set, query_set;
    logic [1:0] inv_way, touch_way, resp_way;
    logic       resp_valid, resp_inv, busy;
    logic [3:0] resp_max;

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    int m_stamp [NS][NW];
    bit m_valid [NS][NW];
    bit m_renorm;
    int m_lat_set, m_lat_way;

    tlb_lru_tracker #(.NUM_WAYS(NW), .NUM_SETS(NS), .LRU_BITS(LB)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .inv_valid   (inv_valid),
        .inv_set     (inv_set),
        .inv_way     (inv_way),
        .touch_valid (touch_valid),
        .touch_ready (touch_ready),
        .touch_set   (touch_set),
        .touch_way   (touch_way),
        .query_valid (query_valid),
        .query_set   (query_set),
        .resp_valid  (resp_valid),
        .resp_way    (resp_way),
        .resp_max    (resp_max),
        .resp_inv    (resp_inv),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_stamp[s][w] = 0;
                m_valid[s][w] = 1'b0;
            end
        m_renorm = 1'b0;
    endtask

    function automatic int m_max(input int s);
        int mx = 0;
        for (int w = 0; w < NW; w++)
            if (m_stamp[s][w] > mx) mx = m_stamp[s][w];
        return mx;
    endfunction

    task automatic m_query(input int s, output int way, output int mx, output bit inv);
        inv = 1'b0;
        way = 0;
        mx  = m_max(s);
        for (int w = NW - 1; w >= 0; w--)
            if (!m_valid[s][w]) begin
                inv = 1'b1;
                way = w;
            end
        if (!inv)
            for (int w = 1; w < NW; w++)
                if (m_stamp[s][w] < m_stamp[s][way]) way = w;
    endtask

    // Sort the non-latched ways by (stamp, index) and hand out 0,1,2,...
    task automatic m_renorm_apply();
        int order[$];
        int s  = m_lat_set;
        int lw = m_lat_way;
        for (int w = 0; w < NW; w++) begin
            if (w != lw) begin
                int pos;
                pos = order.size();
                for (int k = 0; k < order.size(); k++)
                    if (m_stamp[s][w] < m_stamp[s][order[k]]) begin
                        pos = k;
                        break;
                    end
                order.insert(pos, w);
            end
        end
        for (int k = 0; k < order.size(); k++) m_stamp[s][order[k]] = k;
        m_stamp[s][lw] = NW;
        m_valid[s][lw] = 1'b1;
    endtask

    // One clock: drive at negedge, check handshake before the edge, response after it.
    task automatic cyc(input bit f, input bit iv, input int is, input int iw,
                       input bit tv, input int ts, input int tw, input bit qv, input int qs);
        int e_way, e_max;
        bit e_inv, e_ready;
        flush = f; inv_valid = iv; inv_set = 4'(is); inv_way = 2'(iw);
        touch_valid = tv; touch_set = 4'(ts); touch_way = 2'(tw);
        query_valid = qv; query_set = 4'(qs);
        m_query(qs, e_way, e_max, e_inv);
        e_ready = !f && !iv && !m_renorm;
        #1;
        check("touch_ready", touch_ready, e_ready);
        check("busy", busy, m_renorm);
        @(posedge clk);
        if (f) m_clear();
        else begin
            if (m_renorm) begin
                m_renorm_apply();
                m_renorm = 1'b0;
            end else if (tv && e_ready) begin
                if (m_max(ts) < SAT) begin
                    m_stamp[ts][tw] = m_max(ts) + 1;
                    m_valid[ts][tw] = 1'b1;
                end else begin
                    m_lat_set = ts;
                    m_lat_way = tw;
                    m_renorm  = 1'b1;
                end
            end
            if (iv) begin
                m_stamp[is][iw] = 0;
                m_valid[is][iw] = 1'b0;
            end
        end
        @(negedge clk);
        check("resp_valid", resp_valid, qv);
        if (qv) begin
            check("resp_way", resp_way, e_way);
            check("resp_max", resp_max, e_max);
            check("resp_inv", resp_inv, e_inv);
        end
    endtask

    task automatic touch(input int s, input int w);
        cyc(0, 0, 0, 0, 1, s, w, 0, 0);
    endtask

    task automatic query(input int s);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, s);
    endtask

    task automatic do_reset(input bit qv, input int qs);
        rst = 1'b1; flush = 1'b0; inv_valid = 1'b0; touch_valid = 1'b0;
        query_valid = qv; query_set = 4'(qs);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        query_valid = 1'b0;
        m_clear();
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_way", resp_way, 0);
        check("rst_resp_max", resp_max, 0);
        check("rst_resp_inv", resp_inv, 0);
        check("rst_busy", busy, 0);
        check("rst_touch_ready", touch_ready, 1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inv_valid = 1'b0; touch_valid = 1'b0; query_valid = 1'b0;
        inv_set = '0; inv_way = '0; touch_set = '0; touch_way = '0; query_set = '0;
        m_lat_set = 0; m_lat_way = 0;
        m_clear();
        @(negedge clk);
        do_reset(0, 0);
        @(negedge clk);

        // Empty tracker: lowest invalid way, one-cycle latency.
        query(0);
        check("t1_way", resp_way, 0);
        check("t1_inv", resp_inv, 1);
        check("t1_max", resp_max, 0);
        query(3);

        // Fill a set in order, then re-touch the LRU way.
        for (int w = 0; w < NW; w++) touch(5, w);
        query(5);
        check("t2_way", resp_way, 0);
        check("t2_max", resp_max, 4);
        check("t2_inv", resp_inv, 0);
        touch(5, 0);
        query(5);
        check("t2_way_after", resp_way, 1);
        check("t2_max_after", resp_max, 5);

        // Invalidated ways take precedence, lowest index first.
        for (int w = 0; w < NW; w++) touch(6, w);
        cyc(0, 1, 6, 3, 0, 0, 0, 1, 6);
        query(6);
        check("t3_inv_way", resp_way, 3);
        cyc(0, 1, 6, 1, 0, 0, 0, 0, 0);
        touch(6, 3);
        query(6);
        check("t3_low_inv", resp_way, 1);

        // Saturation: stamps {12,13,14,15}, touch way 1 -> renormalise to {0,4,1,2}.
        for (int k = 1; k <= SAT; k++) touch(7, k % NW);
        query(7);
        check("t4_pre_max", resp_max, 15);
        touch(7, 1);
        query(7);
        query(7);
        check("t4_way", resp_way, 0);
        check("t4_max", resp_max, 4);
        cyc(0, 1, 7, 1, 0, 0, 0, 0, 0);
        query(7);
        check("t4_compress", resp_max, 2);

        // Invalidate beats a same-cycle touch; query sees pre-update state.
        touch(2, 0);
        touch(2, 1);
        cyc(0, 1, 2, 0, 1, 2, 2, 1, 2);
        check("t5_pre_way", resp_way, 2);
        cyc(0, 0, 0, 0, 1, 2, 2, 1, 2);
        query(2);

        // Invalidate during renormalise on the same set.
        touch(3, 1);
        for (int k = 0; k < SAT - 1; k++) touch(3, 0);
        touch(3, 2);
        cyc(0, 1, 3, 1, 0, 0, 0, 1, 3);
        query(3);
        check("t5b_max", resp_max, 4);

        // Flush during renormalise drops the latched touch.
        for (int k = 0; k <= SAT; k++) touch(9, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 9);
        query(9);
        check("t6_way", resp_way, 0);
        check("t6_inv", resp_inv, 1);
        check("t6_max", resp_max, 0);
        query(5);

        // Reset in the middle of traffic, with a query issued during reset.
        touch(4, 2);
        do_reset(1, 4);
        @(negedge clk);
        query(5);

        // Random traffic on a few sets so saturation recurs.
        for (int n = 0; n < 600; n++) begin
            bit f, iv, tv, qv;
            f  = ($urandom_range(0, 79) == 0);
            iv = ($urandom_range(0, 7) == 0);
            tv = ($urandom_range(0, 1) == 1);
            qv = ($urandom_range(0, 1) == 1);
            cyc(f, iv, $urandom_range(0, 3), $urandom_range(0, NW - 1),
                tv, $urandom_range(0, 3), $urandom_range(0, NW - 1),
                qv, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
